led_stream_receiver: RTL and testbench
======================================

// Module: led_stream_receiver
// PURPOSE
//  Receiving end of the 2-wire LED link (clock + data, MSB-first 24-bit RGB per LED, frames separated by an idle gap).
//  Deserialises the stream driven by the LED driver back into a per-LED RGB frame buffer.
//  Used for loopback self-check on the board and as the input stage of a daisy-chained secondary display.
// PARAMETERS
//  LEDS        50     max LEDs per frame; pixels beyond this are dropped
//  GAP_CYCLES  25000  clk cycles with no rising edge that end a frame (500us @ 50MHz)
//  SYNC_STAGES 2      flops in each input synchroniser (>=2)
// PORTS
//  clk         in   1                 system clock
//  rst         in   1                 reset rst, synchronous, active-high
//  ledClockIn  in   1                 async LED link clock
//  ledDataIn   in   1                 async LED link data, sampled on ledClockIn rising edge
//  rdAddr      in   $clog2(LEDS)      read index into committed frame
//  rdData      out  24                committed RGB at rdAddr, registered, 1-cycle read latency
//  frameDone   out  1                 1-cycle pulse when a frame is committed
//  frameLeds   out  $clog2(LEDS+1)    whole pixels in last committed frame (saturates at LEDS)
//  overflowErr out  1                 last committed frame had >LEDS pixels
//  partialErr  out  1                 last committed frame ended with 1..23 leftover bits
// BEHAVIOUR
//  Reset: all outputs 0, both buffer banks' contents undefined but rdData=0, state HUNT. Reset mid-frame discards all progress.
//  Inputs pass SYNC_STAGES flops; rising edge = synced clock 0->1 (one clk later). Data sampled from the same synced stage as the edge.
//  Edge-to-shift latency SYNC_STAGES+1 clk; link clock must be <= clk/4.
//  gapCnt: cleared on every rising edge, else increments, saturating at GAP_CYCLES; gap = (gapCnt==GAP_CYCLES).
//  FSM:
//   HUNT   ignore edges until gap -> IDLE (never start mid-frame after reset)
//   IDLE   on edge: shift bit in, bitCnt=1, pixCnt=0 -> RECV
//   RECV   on edge: shift in; at 24th bit write pixel to write bank at pixCnt if pixCnt<LEDS, else set ovf; pixCnt++ (saturating at LEDS), bitCnt=0
//          on gap -> COMMIT
//   COMMIT one cycle: swap banks, frameDone=1, frameLeds=pixCnt, overflowErr=ovf, partialErr=(bitCnt!=0); clear ovf/bitCnt -> IDLE
//  Edge arriving in COMMIT is held by the edge flop and taken in IDLE next cycle (no bit lost).
//  Pixel write and gap never coincide (gap requires no edge for GAP_CYCLES).
//  Double buffer: reads always see the last committed frame; a frame of 0 pixels still commits (frameLeds=0).
//  Error flags and frameLeds hold until the next COMMIT.
// CONFIGURATION
//  LED_RX_GLITCH_FILTER_EN defined: after synchroniser, 3-sample majority filter on clock and data; edge latency +2 clk; link clock <= clk/8.
//  Undefined: no filter; latency and limits as above.
// STRUCTURE
//  Package CCHW: typedef logic [23:0] rgb_t; localparam LED_BITS_PER_PIXEL = 24; enum led_rx_state_t {HUNT, IDLE, RECV, COMMIT}.
//  Sub-module led_rx_sync_edge: synchroniser chain, optional majority filter, rising-edge pulse + aligned data bit.
//  Top holds FSM, gap counter, shift register, two LEDS x 24 banks (inferable RAM, registered read).
// TESTING
//  Reset, then 3 pixels 0xFF0000,0x00FF00,0x0000FF, gap -> no frameDone (HUNT); same again -> frameDone, frameLeds=3, rdData[1]=0x00FF00.
//  Frame of LEDS+2 pixels, gap -> frameLeds=LEDS, overflowErr=1, rdData[LEDS-1]=last in-range pixel; next clean frame clears overflowErr.
//  2 pixels + 7 extra bits, gap -> frameLeds=2, partialErr=1.
//  Read during reception of frame N+1 -> rdData returns frame N values until frameDone of N+1.
//  Idle gap of GAP_CYCLES-1 between two bursts -> treated as one frame (single frameDone, pixel count summed).
//  Assert rst mid-frame, then gap, then 1 pixel 0x123456, gap -> frameLeds=1, rdData[0]=0x123456; with LED_RX_GLITCH_FILTER_EN, 1-clk clock glitches inserted -> same result.

Source files
------------

// File: rtl/led_stream_receiver_pkg.sv
// Shared types for the LED link receiver: pixel type, bits per pixel and FSM states.
// Optional build macro used by this block: LED_RX_GLITCH_FILTER_EN.
package CCHW;
  localparam int LED_BITS_PER_PIXEL = 24;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    HUNT,
    IDLE,
    RECV,
    COMMIT
  } led_rx_state_t;
endpackage

// File: rtl/led_stream_receiver_sync_edge.sv
// Synchronises the async LED link clock/data, optionally majority-filters them (LED_RX_GLITCH_FILTER_EN),
// and produces a rising-edge flag with the data bit captured on that edge.
module led_rx_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic link_clk_i,
  input  logic link_dat_i,
  input  logic hold_i,
  output logic edge_o,
  output logic bit_o
);
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic clk_f;
  logic dat_f;
  logic clk_prev_q;
  logic edge_q;
  logic bit_q;
  logic rise;

  always_ff @(posedge clk) begin
    if (rst) clk_sync_q <= '0;
    else     clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], link_clk_i};
  end

  always_ff @(posedge clk) begin
    dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], link_dat_i};
  end

`ifdef LED_RX_GLITCH_FILTER_EN
  logic [2:0] clk_hist_q;
  logic [2:0] dat_hist_q;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) clk_hist_q <= '0;
    else     clk_hist_q <= {clk_hist_q[1:0], clk_sync_q[SYNC_STAGES-1]};
  end

  always_ff @(posedge clk) begin
    dat_hist_q <= {dat_hist_q[1:0], dat_sync_q[SYNC_STAGES-1]};
  end

  assign clk_f = maj3(clk_hist_q);
  assign dat_f = maj3(dat_hist_q);
`else
  assign clk_f = clk_sync_q[SYNC_STAGES-1];
  assign dat_f = dat_sync_q[SYNC_STAGES-1];
`endif

  assign rise = clk_f & ~clk_prev_q;

  // The edge flag stays set while the FSM is busy committing so no bit is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_q <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      clk_prev_q <= clk_f;
      edge_q     <= rise | (edge_q & hold_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rise) bit_q <= dat_f;
  end

  assign edge_o = edge_q;
  assign bit_o  = bit_q;
endmodule

// File: rtl/led_stream_receiver.sv
// LED link receiver: deserialises MSB-first 24-bit RGB pixels into a double-buffered frame store.
// Build option LED_RX_GLITCH_FILTER_EN enables a majority filter in the input stage.
module led_stream_receiver
  import CCHW::*;
#(
  parameter int LEDS        = 50,
  parameter int GAP_CYCLES  = 25000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ledClockIn,
  input  logic                       ledDataIn,
  input  logic [$clog2(LEDS)-1:0]    rdAddr,
  output logic [23:0]                rdData,
  output logic                       frameDone,
  output logic [$clog2(LEDS+1)-1:0]  frameLeds,
  output logic                       overflowErr,
  output logic                       partialErr
);
  localparam int ADDR_W = $clog2(LEDS);
  localparam int CNT_W  = $clog2(LEDS + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [4:0] LAST_BIT = 5'(LED_BITS_PER_PIXEL - 1);

  led_rx_state_t state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              ovf_q, ovf_d;
  logic              wr_bank_q, wr_bank_d;
  rgb_t              sr_q, sr_d;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  rgb_t              wr_data;
  logic              link_edge;
  logic              link_bit;
  logic              gap;

  logic              frame_done_q;
  logic [CNT_W-1:0]  frame_leds_q;
  logic              ovf_err_q;
  logic              part_err_q;
  rgb_t              rd_data_q;
  rgb_t              bank0_q [LEDS];
  rgb_t              bank1_q [LEDS];

  led_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .link_clk_i (ledClockIn),
    .link_dat_i (ledDataIn),
    .hold_i     (state_q == COMMIT),
    .edge_o     (link_edge),
    .bit_o      (link_bit)
  );

  assign gap = (gap_cnt_q == GAP_W'(GAP_CYCLES));

  always_ff @(posedge clk) begin
    if (rst)            gap_cnt_q <= '0;
    else if (link_edge) gap_cnt_q <= '0;
    else if (!gap)      gap_cnt_q <= gap_cnt_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pix_cnt_d = pix_cnt_q;
    ovf_d     = ovf_q;
    wr_bank_d = wr_bank_q;
    sr_d      = sr_q;
    we        = 1'b0;
    wr_addr   = pix_cnt_q[ADDR_W-1:0];
    wr_data   = {sr_q[22:0], link_bit};
    case (state_q)
      HUNT: begin
        if (gap) state_d = IDLE;
      end
      IDLE: begin
        if (link_edge) begin
          sr_d      = {sr_q[22:0], link_bit};
          bit_cnt_d = 5'd1;
          pix_cnt_d = '0;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (link_edge) begin
          sr_d = {sr_q[22:0], link_bit};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (int'(pix_cnt_q) < LEDS) begin
              we        = 1'b1;
              pix_cnt_d = pix_cnt_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (gap) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        wr_bank_d = ~wr_bank_q;
        ovf_d     = 1'b0;
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      bit_cnt_q <= '0;
      pix_cnt_q <= '0;
      ovf_q     <= 1'b0;
      wr_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      ovf_q     <= ovf_d;
      wr_bank_q <= wr_bank_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  // Frame status is captured as the banks swap, so it lines up with the new read bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_q <= 1'b0;
      frame_leds_q <= '0;
      ovf_err_q    <= 1'b0;
      part_err_q   <= 1'b0;
    end else begin
      frame_done_q <= (state_q == COMMIT);
      if (state_q == COMMIT) begin
        frame_leds_q <= pix_cnt_q;
        ovf_err_q    <= ovf_q;
        part_err_q   <= (bit_cnt_q != 5'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      if (wr_bank_q) bank1_q[wr_addr] <= wr_data;
      else           bank0_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (int'(rdAddr) < LEDS) begin
      rd_data_q <= wr_bank_q ? bank0_q[rdAddr] : bank1_q[rdAddr];
    end
  end

  assign rdData      = rd_data_q;
  assign frameDone   = frame_done_q;
  assign frameLeds   = frame_leds_q;
  assign overflowErr = ovf_err_q;
  assign partialErr  = part_err_q;
endmodule

// File: tb/tb_led_stream_receiver.sv
// Directed-sequence bench for led_stream_receiver with random pixel payloads and a frame-level reference model.
module tb_led_stream_receiver;
  localparam int LEDS = 8;
  localparam int GAP  = 200;
  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ledClockIn;
  logic        ledDataIn;
  logic [2:0]  rdAddr;
  logic [23:0] rdData;
  logic        frameDone;
  logic [3:0]  frameLeds;
  logic        overflowErr;
  logic        partialErr;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  bit glitch_en = 1'b0;
  bit frame_bits[$];
  logic [23:0] exp_mem [LEDS];

  led_stream_receiver #(.LEDS(LEDS), .GAP_CYCLES(GAP), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .ledClockIn  (ledClockIn),
    .ledDataIn   (ledDataIn),
    .rdAddr      (rdAddr),
    .rdData      (rdData),
    .frameDone   (frameDone),
    .frameLeds   (frameLeds),
    .overflowErr (overflowErr),
    .partialErr  (partialErr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frameDone === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send_bit(input bit b);
    ledDataIn = b;
    for (int i = 0; i < HALF; i++) begin
      @(negedge clk);
      if (glitch_en) ledClockIn = (i == 0);
    end
    ledClockIn = 1'b1;
    repeat (HALF) @(negedge clk);
    ledClockIn = 1'b0;
    frame_bits.push_back(b);
  endtask

  task automatic send_pix(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic rd(input int a, output logic [23:0] d);
    @(negedge clk) rdAddr = 3'(a);
    @(negedge clk) d = rdData;
  endtask

  // Frame-level model: whole pixels, saturation, leftover bits, committed contents.
  task automatic end_frame(input bit expect_commit);
    int d0;
    int n;
    int nl;
    logic [23:0] px;
    logic [23:0] got;
    d0 = done_cnt;
    repeat (GAP + 30) @(negedge clk);
    chk("frameDone count", done_cnt - d0, expect_commit ? 1 : 0);
    if (expect_commit) begin
      n  = frame_bits.size() / 24;
      nl = (n < LEDS) ? n : LEDS;
      for (int p = 0; p < nl; p++) begin
        px = '0;
        for (int b = 0; b < 24; b++) px = {px[22:0], frame_bits[p*24 + b]};
        exp_mem[p] = px;
      end
      chk("frameLeds", frameLeds, nl);
      chk("overflowErr", overflowErr, (n > LEDS) ? 1 : 0);
      chk("partialErr", partialErr, (frame_bits.size() % 24 != 0) ? 1 : 0);
      for (int p = 0; p < nl; p++) begin
        rd(p, got);
        chk($sformatf("rdData[%0d]", p), got, exp_mem[p]);
      end
    end
    frame_bits.delete();
  endtask

  initial begin
    logic [23:0] got;
    rst = 1'b1;
    ledClockIn = 1'b0;
    ledDataIn = 1'b0;
    rdAddr = '0;
    repeat (3) @(negedge clk);
    chk("reset frameDone", frameDone, 0);
    chk("reset frameLeds", frameLeds, 0);
    chk("reset overflowErr", overflowErr, 0);
    chk("reset partialErr", partialErr, 0);
    chk("reset rdData", rdData, 0);
    rst = 1'b0;

    // First frame after reset lands in HUNT and must not commit.
    send_pix(24'hFF0000); send_pix(24'h00FF00); send_pix(24'h0000FF);
    end_frame(1'b0);
    send_pix(24'hFF0000); send_pix(24'h00FF00); send_pix(24'h0000FF);
    end_frame(1'b1);
    rd(1, got);
    chk("rdData[1] green", got, 24'h00FF00);

    // Old frame stays readable while the next one arrives.
    for (int p = 0; p < 5; p++) begin
      send_pix(24'($urandom));
      rd(1, got);
      chk("read during reception", got, 24'h00FF00);
    end
    end_frame(1'b1);

    for (int p = 0; p < LEDS + 2; p++) send_pix(24'($urandom));
    end_frame(1'b1);
    for (int p = 0; p < 4; p++) send_pix(24'($urandom));
    end_frame(1'b1);

    send_pix(24'($urandom)); send_pix(24'($urandom));
    for (int i = 0; i < 7; i++) send_bit(1'($urandom));
    end_frame(1'b1);

    // Rising edges GAP-1 cycles apart stay within one frame.
    send_pix(24'($urandom)); send_pix(24'($urandom));
    repeat (GAP - 9) @(negedge clk);
    send_pix(24'($urandom)); send_pix(24'($urandom)); send_pix(24'($urandom));
    end_frame(1'b1);

    for (int i = 0; i < 30; i++) send_bit(1'($urandom));
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("midreset frameLeds", frameLeds, 0);
    chk("midreset rdData", rdData, 0);
    chk("midreset overflowErr", overflowErr, 0);
    rst = 1'b0;
    frame_bits.delete();
    repeat (GAP + 30) @(negedge clk);
`ifdef LED_RX_GLITCH_FILTER_EN
    glitch_en = 1'b1;
`endif
    send_pix(24'h123456);
    glitch_en = 1'b0;
    end_frame(1'b1);
    rd(0, got);
    chk("rdData[0] after reset", got, 24'h123456);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
